// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: IM request/response, redirect, and the ID-side pop port.
`timescale 1ns/1ps
interface if_fetch_queue_if;
  logic        im_req_valid;
  logic        im_req_ready;
  logic [31:0] im_req_addr;
  logic        im_rsp_valid;
  logic [31:0] im_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  // master = the fetch queue itself
  modport master (
    output im_req_valid, im_req_addr, if_valid, if_instr, if_pc,
    input  im_req_ready, im_rsp_valid, im_rsp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  im_req_valid, im_req_addr, if_valid, if_instr, if_pc,
    output im_req_ready, im_rsp_valid, im_rsp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Fetch PC owner + DEPTH-entry {pc,instr} FIFO; response visible at if_valid one cycle after arrival.
// Requests are credit-limited (count + outstanding < DEPTH) so a push never meets a full FIFO.
`timescale 1ns/1ps
module if_fetch_queue #(
  parameter logic [31:0] PC_INIT = 32'h0000_3000,
  parameter int          DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  if_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;

  logic [CW:0]   w_inflight;
  logic          w_req_fire;
  logic          w_rsp_ok;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_pc;

  assign w_inflight   = {1'b0, r_count} + {1'b0, r_outstanding};
  assign bus.im_req_valid = reset & ~bus.redirect_valid & (w_inflight < (CW+1)'(DEPTH));
  assign bus.im_req_addr  = r_fetch_pc;
  assign w_req_fire   = bus.im_req_valid & bus.im_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored entirely.
  assign w_rsp_ok     = bus.im_rsp_valid & (r_outstanding != '0);
  assign w_drop       = w_rsp_ok & ((r_drop_cnt != '0) | bus.redirect_valid);
  assign w_push       = w_rsp_ok & ~w_drop;
  assign w_pop        = bus.if_valid & bus.id_ready & ~bus.redirect_valid;
  assign w_redirect_pc = bus.redirect_pc & ~32'h3;

  assign bus.if_valid = (r_count != '0);
  assign bus.if_pc    = bus.if_valid ? r_mem[r_rd_ptr].pc    : '0;
  assign bus.if_instr = bus.if_valid ? r_mem[r_rd_ptr].instr : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= PC_INIT;
      r_rsp_pc      <= PC_INIT;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_ok);
      if (bus.redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_drop_cnt <= r_outstanding - CW'(w_rsp_ok);
      end else begin
        if (w_req_fire)
          r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + 32'd4;
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_rsp_ok && (r_drop_cnt != '0))
          r_drop_cnt <= r_drop_cnt - CW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= '{pc: r_rsp_pc, instr: bus.im_rsp_data};
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue; IM returns {16'hDEAD, addr[15:0]} after a set latency.
`timescale 1ns/1ps
module tb_if_fetch_queue;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   n_fire;
  int   cyc;
  int   lat;
  logic [31:0] q_addr[$];
  int          q_due[$];

  if_fetch_queue_if bus ();

  if_fetch_queue #(.PC_INIT(32'h0000_3000), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record a handshake, cross the edge, present any due IM response.
  task automatic tick();
    logic [31:0] a;
    #1;
    if (bus.im_req_valid === 1'b1 && bus.im_req_ready === 1'b1) begin
      q_addr.push_back(bus.im_req_addr);
      q_due.push_back(cyc + lat);
      n_fire++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (q_due.size() != 0 && q_due[0] == cyc) begin
      a = q_addr.pop_front();
      void'(q_due.pop_front());
      bus.im_rsp_valid = 1'b1;
      bus.im_rsp_data  = {16'hDEAD, a[15:0]};
    end else begin
      bus.im_rsp_valid = 1'b0;
      bus.im_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    q_addr.delete();
    q_due.delete();
    bus.im_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();
    reset = 1'b1;
    n_fire = 0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; n_fire = 0; cyc = 0; lat = 1;
    reset = 1'b0;
    bus.im_req_ready   = 1'b1;
    bus.im_rsp_valid   = 1'b0;
    bus.im_rsp_data    = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b1;
    #1;
    chk("rst_req_valid", 32'(bus.im_req_valid), 32'd0);
    chk("rst_if_valid",  32'(bus.if_valid),     32'd0);
    chk("rst_if_pc",     bus.if_pc,             32'd0);
    chk("rst_if_instr",  bus.if_instr,          32'd0);

    // 1) streaming with a 1-cycle IM
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("s1_c0_valid", 32'(bus.im_req_valid), 32'd1);
    chk("s1_c0_addr",  bus.im_req_addr,       32'h0000_3000);
    chk("s1_c0_ifv",   32'(bus.if_valid),     32'd0);
    tick();
    chk("s1_c1_addr",  bus.im_req_addr,       32'h0000_3004);
    chk("s1_c1_ifv",   32'(bus.if_valid),     32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("s1_ifv",   32'(bus.if_valid), 32'd1);
      chk("s1_pc",    bus.if_pc,         32'h0000_3000 + 32'(4 * k));
      chk("s1_instr", bus.if_instr,      32'hDEAD_3000 + 32'(4 * k));
      chk("s1_addr",  bus.im_req_addr,   32'h0000_3008 + 32'(4 * k));
      tick();
    end

    // 2) ID stalled: credits stop requests at 4
    bus.id_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    chk("s2_fires",     32'(n_fire),            32'd4);
    chk("s2_req_valid", 32'(bus.im_req_valid),  32'd0);
    chk("s2_ifv",       32'(bus.if_valid),      32'd1);
    chk("s2_pc",        bus.if_pc,              32'h0000_3000);
    bus.id_ready = 1'b1;
    #1;
    chk("s2_pop_cyc_req", 32'(bus.im_req_valid), 32'd0);
    tick();
    bus.id_ready = 1'b0;
    #1;
    chk("s2_new_req",   32'(bus.im_req_valid),  32'd1);
    chk("s2_new_addr",  bus.im_req_addr,        32'h0000_3010);
    chk("s2_pc_after",  bus.if_pc,              32'h0000_3004);
    tick(); tick(); tick();
    chk("s2_fires2",    32'(n_fire),            32'd5);
    chk("s2_req_off",   32'(bus.im_req_valid),  32'd0);
    chk("s2_pc_hold",   bus.if_pc,              32'h0000_3004);

    // 3) redirect with 3 requests outstanding (IM latency 4)
    bus.id_ready = 1'b1;
    lat = 4;
    do_reset();
    tick(); tick(); tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_4002;
    #1;
    chk("s3_redir_req", 32'(bus.im_req_valid), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("s3_addr",      bus.im_req_addr,       32'h0000_4000);
    chk("s3_req_valid", 32'(bus.im_req_valid), 32'd1);
    chk("s3_ifv_early", 32'(bus.if_valid),     32'd0);
    for (int i = 0; i < 12 && bus.if_valid !== 1'b1; i++) tick();
    chk("s3_ifv",       32'(bus.if_valid),     32'd1);
    chk("s3_pc",        bus.if_pc,             32'h0000_4000);
    chk("s3_instr",     bus.if_instr,          32'hDEAD_4000);
    tick();
    chk("s3_pc2",       bus.if_pc,             32'h0000_4004);

    // 4) redirect together with a response and a pop
    lat = 1;
    do_reset();
    tick(); tick();
    chk("s4_pre_pc",    bus.if_pc,             32'h0000_3000);
    chk("s4_pre_rsp",   32'(bus.im_rsp_valid), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_5000;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("s4_ifv_empty", 32'(bus.if_valid),     32'd0);
    chk("s4_addr",      bus.im_req_addr,       32'h0000_5000);
    tick(); tick();
    chk("s4_pc",        bus.if_pc,             32'h0000_5000);
    chk("s4_instr",     bus.if_instr,          32'hDEAD_5000);

    // 5) asynchronous reset mid-burst
    tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    chk("s5_ifv",       32'(bus.if_valid),     32'd0);
    chk("s5_req",       32'(bus.im_req_valid), 32'd0);
    chk("s5_pc",        bus.if_pc,             32'd0);
    q_addr.delete();
    q_due.delete();
    bus.im_rsp_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("s5_addr",      bus.im_req_addr,       32'h0000_3000);
    chk("s5_req_valid", 32'(bus.im_req_valid), 32'd1);

    // 6) PC wrap at the top of the address space
    tick(); tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("s6_addr_top",  bus.im_req_addr,       32'hFFFF_FFFC);
    tick();
    chk("s6_addr_wrap", bus.im_req_addr,       32'h0000_0000);
    tick();
    chk("s6_pc_top",    bus.if_pc,             32'hFFFF_FFFC);
    chk("s6_instr_top", bus.if_instr,          32'hDEAD_FFFC);
    tick();
    chk("s6_pc_wrap",   bus.if_pc,             32'h0000_0000);
    chk("s6_instr_wrap", bus.if_instr,         32'hDEAD_0000);

    // 7) stray response with nothing outstanding is ignored
    do_reset();
    bus.im_req_ready = 1'b0;
    bus.im_rsp_valid = 1'b1;
    bus.im_rsp_data  = 32'h1234_5678;
    tick();
    #1;
    chk("s7_ifv",       32'(bus.if_valid),     32'd0);
    chk("s7_req_valid", 32'(bus.im_req_valid), 32'd1);
    chk("s7_addr",      bus.im_req_addr,       32'h0000_3000);
    tick();
    chk("s7_ifv2",      32'(bus.if_valid),     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
